// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// fetch_stage: single-outstanding instruction fetch unit.
// Requests one word at pc, waits for the response, holds it for decode, and
// follows redirects from execute. A redirect always wins over other events.
// If a redirect lands while a request is in flight, that response is discarded.
// Optional feature: define FETCH_MISALIGN_CHK_EN to flag non-word-aligned
// redirect targets. The flag is sticky and stops fetching until an aligned
// redirect or reset.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [6:0]  if_opcode,
  output logic [2:0]  if_funct3,
  output logic [6:0]  if_funct7,
  output logic        fetch_fault
);

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic        kill_q, kill_d;

  logic [31:0] redir_pc_s;
  logic        fault_s;
  logic        grant_s;

`ifdef FETCH_MISALIGN_CHK_EN
  logic fault_q, fault_d;

  // Next value of the fault flag: only a redirect can set or clear it.
  always_comb begin
    if (redirect_valid) begin
      fault_d = (redirect_pc[1:0] != 2'b00);
    end else begin
      fault_d = fault_q;
    end
  end

  // Sticky misaligned-target flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_q <= 1'b0;
    end else begin
      fault_q <= fault_d;
    end
  end

  assign fault_s    = fault_q;
  assign redir_pc_s = redirect_pc;
`else
  // Without the check the low target bits are dropped, so the pc stays word aligned.
  logic unused_redir_lsb_s;
  assign unused_redir_lsb_s = ^redirect_pc[1:0];
  assign fault_s            = 1'b0;
  assign redir_pc_s         = {redirect_pc[31:2], 2'b00};
`endif

  // A request is never shown while reset is asserted or while a fault blocks fetching.
  assign imem_req    = (state_q == S_REQ) && !fault_s && !rst;
  assign imem_addr   = pc_q;
  assign grant_s     = imem_req && imem_gnt;

  assign if_valid    = (state_q == S_HOLD) && !fault_s;
  assign if_instr    = if_instr_q;
  assign if_pc       = if_pc_q;
  assign if_opcode   = if_instr_q[6:0];
  assign if_funct3   = if_instr_q[14:12];
  assign if_funct7   = if_instr_q[31:25];
  assign fetch_fault = fault_s;

  // Next fetch address: a redirect wins, otherwise advance after a delivered word.
  always_comb begin
    if (redirect_valid) begin
      pc_d = redir_pc_s;
    end else if ((state_q == S_WAIT) && imem_rvalid && !kill_q) begin
      pc_d = pend_pc_q + 32'd4;
    end else begin
      pc_d = pc_q;
    end
  end

  // Next-state logic: request, wait for the response, hold the word for decode.
  always_comb begin
    state_d    = state_q;
    pend_pc_d  = pend_pc_q;
    kill_d     = kill_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      S_REQ: begin
        if (grant_s) begin
          // A redirect in the grant cycle poisons the request just issued.
          state_d   = S_WAIT;
          pend_pc_d = pc_q;
          kill_d    = redirect_valid;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          kill_d = 1'b0;
          if (kill_q || redirect_valid) begin
            state_d = S_REQ;
          end else begin
            state_d    = S_HOLD;
            if_instr_d = imem_rdata;
            if_pc_d    = pend_pc_q;
          end
        end else if (redirect_valid) begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_HOLD: begin
        // A redirect drops the held word even if decode accepts it in the same cycle.
        if (redirect_valid || id_ready) begin
          state_d = S_REQ;
        end else begin
          state_d = S_HOLD;
        end
      end
      default: begin
        state_d = S_REQ;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      pend_pc_q  <= RESET_PC;
      kill_q     <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pend_pc_q  <= pend_pc_d;
      kill_q     <= kill_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// tb_fetch_stage: directed scenarios followed by a randomized run.
// A transaction-level reference model of the fetch unit is checked against
// the DUT on every falling clock edge.
module tb_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [6:0]  if_opcode;
  logic [2:0]  if_funct3;
  logic [6:0]  if_funct7;
  logic        fetch_fault;

  fetch_stage #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .if_opcode(if_opcode), .if_funct3(if_funct3), .if_funct7(if_funct7),
    .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  // Memory knobs, written by the main process and read by the memory process.
  int          gnt_pct;
  int          mem_lat;
  // Memory state, written only by the memory process.
  logic        gnt_en;
  logic        have_pend;
  int          pend_lat;
  logic [31:0] pend_data;

  assign imem_gnt = imem_req & gnt_en;

  function automatic logic [31:0] data_for(input logic [31:0] a);
    if (a == 32'd0) return 32'h0050_0093;
    return $urandom;
  endfunction

  // Memory process: accept one request at a time and answer it after mem_lat extra cycles.
  initial begin
    gnt_en = 1'b0; have_pend = 1'b0; pend_lat = 0; pend_data = 32'd0;
    imem_rvalid = 1'b0; imem_rdata = 32'd0;
    forever begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        have_pend = 1'b1;
        pend_lat  = mem_lat;
        pend_data = data_for(imem_addr);
      end
      @(posedge clk);
      #1;
      imem_rvalid = 1'b0;
      if (have_pend) begin
        if (pend_lat == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = pend_data;
          have_pend   = 1'b0;
        end else begin
          pend_lat = pend_lat - 1;
        end
      end
      gnt_en = !have_pend && ($urandom_range(0, 99) < gnt_pct);
    end
  end

  // ---------------- reference model ----------------
  logic        m_known = 1'b0;
  logic [31:0] m_pc;
  logic        m_out, m_kill, m_hold, m_fault, m_loaded;
  logic [31:0] m_out_pc, m_instr, m_ipc;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual %h required %h", name, act, exp);
  endtask

  // Compare DUT outputs with what the model says must be visible this cycle.
  task automatic model_check();
    logic exp_req;
    logic [31:0] mi;
    if (rst) chk("req_in_reset", 32'(imem_req), 32'd0);
    if (!m_known) return;
    if (!rst) begin
      exp_req = !m_out && !m_hold && !m_fault;
      chk("imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("imem_addr", imem_addr, m_pc);
    end
    chk("if_valid", 32'(if_valid), 32'(m_hold));
    chk("fetch_fault", 32'(fetch_fault), 32'(m_fault));
    if (m_hold) begin
      mi = m_instr;
      chk("if_instr", if_instr, mi);
      chk("if_pc", if_pc, m_ipc);
      chk("if_opcode", 32'(if_opcode), 32'(mi[6:0]));
      chk("if_funct3", 32'(if_funct3), 32'(mi[14:12]));
      chk("if_funct7", 32'(if_funct7), 32'(mi[31:25]));
    end else if (!m_loaded) begin
      chk("reset_instr", if_instr, NOP);
      chk("reset_pc", if_pc, RST_PC);
    end
  endtask

  // Advance the model across the coming rising edge using the current inputs.
  task automatic model_step();
    logic [31:0] tgt;
    logic        mis;
    logic        req;
`ifdef FETCH_MISALIGN_CHK_EN
    tgt = redirect_pc;
    mis = (redirect_pc[1:0] != 2'b00);
`else
    tgt = {redirect_pc[31:2], 2'b00};
    mis = 1'b0;
`endif
    if (rst) begin
      m_known = 1'b1; m_pc = RST_PC; m_out = 1'b0; m_kill = 1'b0;
      m_hold = 1'b0; m_fault = 1'b0; m_loaded = 1'b0;
    end else if (m_known) begin
      req = !m_out && !m_hold && !m_fault;
      if (m_hold) begin
        if (redirect_valid || id_ready) m_hold = 1'b0;
      end else if (m_out) begin
        if (imem_rvalid) begin
          m_out = 1'b0;
          if (!m_kill && !redirect_valid) begin
            m_hold = 1'b1; m_instr = imem_rdata; m_ipc = m_out_pc;
            m_pc = m_out_pc + 32'd4; m_loaded = 1'b1;
          end
        end else if (redirect_valid) begin
          m_kill = 1'b1;
        end
      end else if (req && imem_gnt) begin
        m_out = 1'b1; m_out_pc = m_pc; m_kill = redirect_valid;
      end
      if (redirect_valid) begin
        m_pc = tgt; m_fault = mis;
      end
    end
  endtask

  // One clock cycle: model check at the falling edge, then move to the next drive/check point.
  task automatic step();
    @(negedge clk);
    model_check();
    model_step();
    @(posedge clk);
    #3;
  endtask

  // ---------------- main stimulus ----------------
  initial begin
    logic [31:0] r;
    rst = 1'b1; id_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    gnt_pct = 100; mem_lat = 0;

    // Reset, then 0-wait fetch of address 0 and 3-cycle throughput.
    step(); step();
    rst = 1'b0; #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'h0000_0000);
    chk("rst_if_valid", 32'(if_valid), 32'd0);
    chk("rst_if_instr", if_instr, 32'h0000_0013);
    chk("rst_if_pc", if_pc, 32'h0000_0000);
    chk("rst_fault", 32'(fetch_fault), 32'd0);
    id_ready = 1'b1;
    step(); chk("wait_req", 32'(imem_req), 32'd0);
    step();
    chk("d1_valid", 32'(if_valid), 32'd1);
    chk("d1_instr", if_instr, 32'h0050_0093);
    chk("d1_opcode", 32'(if_opcode), 32'(7'b0010011));
    chk("d1_pc", if_pc, 32'h0000_0000);
    step(); chk("d1_next_addr", imem_addr, 32'h0000_0004);
    step(); step();
    chk("d1_tp_valid", 32'(if_valid), 32'd1);
    chk("d1_tp_pc", if_pc, 32'h0000_0004);

    // Decode stalls for 5 cycles.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", 32'(if_valid), 32'd1);
      chk("stall_pc", if_pc, 32'h0000_0004);
      chk("stall_req", 32'(imem_req), 32'd0);
    end
    id_ready = 1'b1;
    step(); chk("stall_next_addr", imem_addr, 32'h0000_0008);

    // Redirect during S_WAIT; the stale response arrives one cycle later.
    mem_lat = 1;
    step(); chk("d3_wait", 32'(imem_req), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    step();
    redirect_valid = 1'b0; mem_lat = 0;
    step();
    chk("d3_no_valid", 32'(if_valid), 32'd0);
    chk("d3_req", 32'(imem_req), 32'd1);
    chk("d3_addr", imem_addr, 32'h0000_0100);

    // Redirect in the grant cycle, then wrap from the top of the address space.
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step(); redirect_valid = 1'b0;
    step();
    chk("d4_addr", imem_addr, 32'hFFFF_FFFC);
    chk("d4_no_valid", 32'(if_valid), 32'd0);
    step(); step();
    chk("d4_valid", 32'(if_valid), 32'd1);
    chk("d4_pc", if_pc, 32'hFFFF_FFFC);
    step(); chk("d4_wrap_addr", imem_addr, 32'h0000_0000);

    // Redirect together with id_ready in S_HOLD.
    step(); step();
    chk("d5_valid", 32'(if_valid), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0300;
    step(); redirect_valid = 1'b0;
    chk("d5_dropped", 32'(if_valid), 32'd0);
    chk("d5_addr", imem_addr, 32'h0000_0300);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0102;
    step(); redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    chk("d6_fault", 32'(fetch_fault), 32'd1);
    step(); step();
    chk("d6_req_blocked", 32'(imem_req), 32'd0);
    chk("d6_valid_blocked", 32'(if_valid), 32'd0);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    step(); redirect_valid = 1'b0;
    chk("d6_fault_clr", 32'(fetch_fault), 32'd0);
    chk("d6_addr", imem_addr, 32'h0000_0200);
`else
    chk("d6_nofault", 32'(fetch_fault), 32'd0);
    step();
    chk("d6_req", 32'(imem_req), 32'd1);
    chk("d6_aligned", imem_addr, 32'h0000_0100);
`endif

    // Reset mid-transaction; the abandoned response shows up in S_REQ.
    mem_lat = 2;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; mem_lat = 0;
    for (int i = 0; i < 10 && !if_valid; i++) step();
    chk("d7_valid", 32'(if_valid), 32'd1);
    chk("d7_pc", if_pc, 32'h0000_0000);
    chk("d7_instr", if_instr, 32'h0050_0093);

    // Randomized traffic.
    gnt_pct = 60;
    for (int i = 0; i < 3000; i++) begin
      id_ready       = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 8);
      r = $urandom;
      if ($urandom_range(0, 7) == 0) r = 32'hFFFF_FFF0 | (r & 32'h0000_000F);
      if ($urandom_range(0, 3) != 0) r[1:0] = 2'b00;
      redirect_pc = r;
      rst         = ($urandom_range(0, 99) == 0);
      mem_lat     = $urandom_range(0, 3);
      step();
    end
    rst = 1'b0; redirect_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of first fetch after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have port imem_addr  output  32  word-aligned fetch address, valid while imem_req=1.
REQ-006 SHALL have port imem_gnt  input  1  memory accepts request this cycle.
REQ-007 SHALL have port imem_rvalid  input  1  response data valid this cycle.
REQ-008 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have ports redirect_valid  input  1  and redirect_pc  input  32: branch/jump target from execute.
REQ-010 SHALL have port id_ready  input  1  decode accepts held instruction.
REQ-011 SHALL have ports if_valid  output  1, if_instr  output  32, if_pc  output  32: instruction to decode.
REQ-012 SHALL have ports if_opcode  output  7 (if_instr[6:0]), if_funct3  output  3 (if_instr[14:12]), if_funct7  output  7 (if_instr[31:25]), driven combinationally from if_instr.
REQ-013 SHALL have port fetch_fault  output  1  misaligned redirect target (see Configuration).

Function
REQ-014 SHALL implement states S_REQ, S_WAIT, S_HOLD; at most one memory request outstanding.
REQ-015 S_REQ: imem_req=1, imem_addr=pc; on imem_gnt latch pend_pc=pc, go S_WAIT; else stay.
REQ-016 S_WAIT: imem_req=0; on imem_rvalid with kill=0 load if_instr=imem_rdata, if_pc=pend_pc, pc=pend_pc+4, go S_HOLD.
REQ-017 S_HOLD: if_valid=1, if_instr/if_pc stable; on id_ready go S_REQ; else hold indefinitely.
REQ-018 if_valid SHALL be 1 only in S_HOLD; handshake completes in the cycle if_valid=1 and id_ready=1.
REQ-019 Unstalled throughput SHALL be one instruction per 3 cycles with 0-wait memory (gnt same cycle, rvalid next cycle).
REQ-020 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-021 redirect_valid SHALL have priority over all other events and set pc=redirect_pc.
REQ-022 Redirect in S_REQ without gnt: go/stay S_REQ, new address on imem_addr next cycle.
REQ-023 Redirect in S_REQ with gnt same cycle: go S_WAIT with kill=1 (issued request's data discarded).
REQ-024 Redirect in S_WAIT without rvalid: set kill=1, stay S_WAIT.
REQ-025 S_WAIT with rvalid and (kill=1 or redirect_valid): discard data, clear kill, go S_REQ, if_valid stays 0.
REQ-026 Redirect in S_HOLD: drop held instruction (even if id_ready=1 same cycle: not delivered), go S_REQ.

Reset
REQ-027 On rst: pc=RESET_PC, state=S_REQ, kill=0, if_valid=0, if_instr=32'h0000_0013 (NOP), if_pc=RESET_PC, fetch_fault=0.
REQ-028 Reset mid-transaction SHALL abandon it; a later imem_rvalid for the abandoned request arriving in S_REQ SHALL be ignored.
REQ-029 imem_req SHALL be 0 during the reset cycle and 1 in the first cycle after rst deasserts.

Configuration
REQ-030 Macro FETCH_MISALIGN_CHK_EN defined: redirect with redirect_pc[1:0]!=2'b00 sets fetch_fault=1 (sticky), suppresses imem_req and if_valid until next aligned redirect or rst.
REQ-031 Macro FETCH_MISALIGN_CHK_EN undefined: redirect_pc[1:0] forced to 2'b00, fetch_fault tied 0, no check logic.

Verification
REQ-032 rst 1 cycle, RESET_PC=0, memory returns 32'h00500093 -> imem_addr=0, if_valid with if_instr=32'h00500093, if_opcode=7'b0010011, if_pc=0.
REQ-033 id_ready=0 for 5 cycles in S_HOLD -> if_instr/if_pc unchanged, imem_req=0 throughout; id_ready=1 -> next imem_addr=4.
REQ-034 Redirect to 32'h0000_0100 while in S_WAIT, stale rvalid next cycle -> stale data never on if_valid; next imem_addr=32'h100.
REQ-035 pc=32'hFFFF_FFFC, deliver and accept -> next imem_addr=32'h0000_0000.
REQ-036 Redirect and id_ready same cycle in S_HOLD -> held instruction dropped, next imem_addr=redirect_pc.
REQ-037 With FETCH_MISALIGN_CHK_EN: redirect to 32'h0000_0102 -> fetch_fault=1, imem_req=0; redirect to 32'h200 -> fetch_fault=0, imem_addr=32'h200.
